cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) among the out-of-order core's functional units. Each unit hands a completed result (ROB tag + value) to a private one-entry holding register. Each cycle the arbiter broadcasts at most one held result on a registered CDB output. The reorder buffer and reservation stations consume that output.

## Interface
- NUM_REQ, 4, number of functional-unit requesters (2..8).
- TAG_WIDTH, 4, ROB tag width.
- DATA_WIDTH, 32, result width.
- Clocking: one clock; reset is synchronous and active-high.
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  pipeline flush; discards all held and in-flight results.
- in_valid  input  NUM_REQ  per-unit result valid.
- in_tag  input  NUM_REQ*TAG_WIDTH  per-unit ROB tag; unit i occupies bits [i*TAG_WIDTH +: TAG_WIDTH].
- in_data  input  NUM_REQ*DATA_WIDTH  per-unit result, packed the same way.
- in_ready  output  NUM_REQ  per-unit accept; a transfer occurs when in_valid[i] & in_ready[i].
- cdb_valid  output  1  registered broadcast valid.
- cdb_tag  output  TAG_WIDTH  registered broadcast ROB tag.
- cdb_data  output  DATA_WIDTH  registered broadcast value.
- cdb_src  output  clog2(NUM_REQ)  index of the unit that owns the current broadcast.
- pending_cnt  output  clog2(NUM_REQ+1)  number of occupied holding registers.

## Operation
- State per unit i:
  - hold_valid[i], hold_tag[i], hold_data[i].
  - Shared rr_ptr (clog2(NUM_REQ) bits) and the CDB output registers.
- in_ready[i] is combinational:
  - Equals (~hold_valid[i] | win[i]) & ~rst & ~flush.
  - A unit whose entry is being broadcast this cycle may refill in the same cycle.
- Arbitration (combinational):
  - Scan hold_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit is the winner; win is one-hot or zero.
- Each rising edge, when neither rst nor flush is asserted:
  - If a winner w exists: cdb_valid<=1, cdb_tag<=hold_tag[w], cdb_data<=hold_data[w], cdb_src<=w, rr_ptr<=(w+1) mod NUM_REQ.
  - If no winner exists: cdb_valid<=0; cdb_tag, cdb_data and cdb_src hold their values; rr_ptr holds.
  - Per unit i:
    - If the input transfers, load hold_* from the inputs and set hold_valid[i]=1.
    - Otherwise, if win[i], clear hold_valid[i].
    - An input transfer has priority over the clear, so a same-cycle refill survives.
- pending_cnt is the registered popcount of hold_valid, updated on the same edge.
- Flush (synchronous):
  - Clears all hold_valid bits and cdb_valid.
  - Holds rr_ptr.
  - Inputs are not accepted in the flush cycle.
- Reset:
  - hold_valid=0, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=0, pending_cnt=0.
  - in_ready=0 while rst is high.
  - Reset asserted mid-operation drops every held result.
- Invariants:
  - At most one broadcast per cycle.
  - A held result is never lost or duplicated, except on flush or rst.
  - Fairness: every held result is broadcast within NUM_REQ cycles of being accepted.

## Timing
- Latency: a result accepted at edge E is broadcast with cdb_valid high from edge E+1 at the earliest. That is 1 cycle through the holding register plus the registered output.
- Throughput: one broadcast per cycle, sustained while any hold_valid is set.
- Worst-case wait is NUM_REQ-1 cycles in the holding register, when all units are full.
- Back-pressure:
  - in_ready[i] is low only when unit i is full and not winning.
  - A unit holding in_valid must keep in_tag and in_data stable until the transfer occurs.
- cdb_* values are valid only in cycles where cdb_valid=1.

## Test plan
- Reset then single request:
  - Stimulus: rst high for 2 cycles, then unit 2 offers tag 5, data 0xDEADBEEF for 1 cycle.
  - Required response: accepted at edge E. At E+1, cdb_valid=1, cdb_tag=5, cdb_data=0xDEADBEEF, cdb_src=2, rr_ptr=3. At E+2, cdb_valid=0. pending_cnt goes 1 then 0.
- All four units request in the same cycle from rr_ptr=0:
  - Stimulus: tags 1..4.
  - Required response: broadcasts on 4 consecutive cycles in order src 0,1,2,3. No cycle carries two results. in_ready stays 1 for each winner.
- Continuous streaming:
  - Stimulus: units 0 and 1 assert in_valid every cycle for 20 cycles.
  - Required response: the CDB alternates src 0/1 every cycle. Each unit sees in_ready low on alternate cycles. All 20 offered results appear exactly once, in per-unit order.
- Wrap-around fairness:
  - Stimulus: rr_ptr=3, units 0 and 3 both held.
  - Required response: unit 3 is broadcast first, then unit 0. rr_ptr wraps 3 -> 0 -> 1.
- Flush with pending results:
  - Stimulus: 3 results held and cdb_valid=1; flush pulsed for 1 cycle while unit 1 also offers a result.
  - Required response: next cycle cdb_valid=0, pending_cnt=0, and unit 1's offered result is not accepted (in_ready[1]=0). rr_ptr is unchanged.
- Reset mid-stream:
  - Stimulus: rst asserted while 2 results are held.
  - Required response: all outputs return to 0 on the next edge. in_ready=0 while rst is high. No stale result is broadcast after rst deasserts.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that broadcasts at most one held functional-unit result per cycle
// on a registered common data bus. Each unit owns a one-entry holding register.
module cdb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int DATA_WIDTH = 32,
  localparam int SRC_W     = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(NUM_REQ + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]  in_tag,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic                          cdb_valid,
  output logic [TAG_WIDTH-1:0]          cdb_tag,
  output logic [DATA_WIDTH-1:0]         cdb_data,
  output logic [SRC_W-1:0]              cdb_src,
  output logic [CNT_W-1:0]              pending_cnt
);

  localparam logic [SRC_W:0] NR = (SRC_W + 1)'(NUM_REQ);

  // Handshake: unit i transfers on a rising edge where in_valid[i] & in_ready[i];
  // the unit must hold in_tag/in_data stable until that transfer happens.

  logic [NUM_REQ-1:0]    hold_valid;
  logic [NUM_REQ-1:0]    hold_valid_nxt;
  logic [TAG_WIDTH-1:0]  hold_tag  [NUM_REQ];
  logic [DATA_WIDTH-1:0] hold_data [NUM_REQ];
  logic [SRC_W-1:0]      rr_ptr;
  logic [SRC_W-1:0]      rr_ptr_nxt;
  logic [SRC_W-1:0]      win_idx;
  logic [NUM_REQ-1:0]    win;
  logic [NUM_REQ-1:0]    xfer;
  logic                  has_win;
  logic [SRC_W:0]        scan;
  logic [CNT_W-1:0]      cnt_nxt;

  // Scan from rr_ptr upward, wrapping modulo NUM_REQ; first held entry wins.
  always_comb begin
    win     = '0;
    win_idx = '0;
    has_win = 1'b0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (SRC_W + 1)'(k);
      if (scan >= NR) scan = scan - NR;
      if (!has_win && hold_valid[scan[SRC_W-1:0]]) begin
        has_win = 1'b1;
        win_idx = scan[SRC_W-1:0];
      end
    end
    if (has_win) win[win_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_nxt = win_idx + SRC_W'(1);
    if (win_idx == SRC_W'(NUM_REQ - 1)) rr_ptr_nxt = '0;
  end

  // A unit being broadcast this cycle may refill in the same cycle.
  assign in_ready       = (~hold_valid | win) & {NUM_REQ{~(rst | flush)}};
  assign xfer           = in_valid & in_ready;
  assign hold_valid_nxt = (hold_valid & ~win) | xfer;

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(hold_valid_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid  <= '0;
      cdb_valid   <= 1'b0;
      cdb_tag     <= '0;
      cdb_data    <= '0;
      cdb_src     <= '0;
      rr_ptr      <= '0;
      pending_cnt <= '0;
    end else if (flush) begin
      hold_valid  <= '0;
      cdb_valid   <= 1'b0;
      pending_cnt <= '0;
    end else begin
      hold_valid  <= hold_valid_nxt;
      pending_cnt <= cnt_nxt;
      cdb_valid   <= has_win;
      if (has_win) begin
        cdb_tag  <= hold_tag[win_idx];
        cdb_data <= hold_data[win_idx];
        cdb_src  <= win_idx;
        rr_ptr   <= rr_ptr_nxt;
      end
    end
  end

  // Payload registers need no reset; hold_valid qualifies them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer[i]) begin
        hold_tag[i]  <= in_tag[i*TAG_WIDTH +: TAG_WIDTH];
        hold_data[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: broadcasts are checked in order against a queue of
// expected {src, tag, data} entries pushed when each result is offered.
module tb_cdb_arbiter;

  localparam int EW = 2 + 4 + 32;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [3:0]   in_valid;
  logic [15:0]  in_tag;
  logic [127:0] in_data;
  logic [3:0]   in_ready;
  logic         cdb_valid;
  logic [3:0]   cdb_tag;
  logic [31:0]  cdb_data;
  logic [1:0]   cdb_src;
  logic [2:0]   pending_cnt;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(4), .TAG_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_tag      (in_tag),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .cdb_src     (cdb_src),
    .pending_cnt (pending_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h required=%0h", name, obs, exp_v);
    end
  endtask

  task automatic check_cdb();
    logic [EW-1:0] e;
    if (cdb_valid === 1'b1) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_bcast observed src=%0d tag=%0h data=%0h required=none",
               cdb_src, cdb_tag, cdb_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("cdb_src",  64'(cdb_src),  64'(e[37:36]));
        chk("cdb_tag",  64'(cdb_tag),  64'(e[35:32]));
        chk("cdb_data", 64'(cdb_data), 64'(e[31:0]));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic offer(input int u, input logic [3:0] t, input logic [31:0] d);
    in_valid[u]        = 1'b1;
    in_tag[u*4 +: 4]   = t;
    in_data[u*32 +: 32] = d;
  endtask

  task automatic exp_push(input int u, input logic [3:0] t, input logic [31:0] d);
    exp_q.push_back({2'(u), t, d});
  endtask

  task automatic idle();
    in_valid = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    check_cdb();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int na;
    int nb;
    logic [1:0] er;
    rst = 1'b1; flush = 1'b0; in_valid = '0; in_tag = '0; in_data = '0;
    na = 0; nb = 0;

    cyc(); cyc();
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb_tag",   64'(cdb_tag),   64'd0);
    chk("rst_cdb_data",  64'(cdb_data),  64'd0);
    chk("rst_cdb_src",   64'(cdb_src),   64'd0);
    chk("rst_pending",   64'(pending_cnt), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);

    // single request from unit 2
    rst = 1'b0;
    offer(2, 4'd5, 32'hDEAD_BEEF); exp_push(2, 4'd5, 32'hDEAD_BEEF);
    #1 chk("single_ready", 64'(in_ready), 64'hF);
    cyc(); idle();
    chk("single_e_valid", 64'(cdb_valid), 64'd0);
    chk("single_e_pend",  64'(pending_cnt), 64'd1);
    cyc();
    chk("single_e1_valid", 64'(cdb_valid), 64'd1);
    chk("single_e1_pend",  64'(pending_cnt), 64'd0);
    cyc();
    chk("single_e2_valid", 64'(cdb_valid), 64'd0);

    // wrap-around from rr_ptr=3: unit 3 then unit 0
    offer(0, 4'hA, 32'h0000_A0A0); offer(3, 4'hB, 32'h0000_B0B0);
    exp_push(3, 4'hB, 32'h0000_B0B0); exp_push(0, 4'hA, 32'h0000_A0A0);
    cyc(); idle();
    chk("wrap_pend2", 64'(pending_cnt), 64'd2);
    cyc();
    chk("wrap_first_valid", 64'(cdb_valid), 64'd1);
    cyc();
    chk("wrap_second_valid", 64'(cdb_valid), 64'd1);
    chk("wrap_pend0", 64'(pending_cnt), 64'd0);

    // bring rr_ptr from 1 to 0 via a lone unit-3 result
    offer(3, 4'd9, 32'h3333_0009); exp_push(3, 4'd9, 32'h3333_0009);
    cyc(); idle(); cyc(); cyc();
    chk("realign_idle", 64'(cdb_valid), 64'd0);

    // all four at once from rr_ptr=0
    for (int k = 0; k < 4; k++) begin
      offer(k, 4'(k + 1), 32'h1000_0000 + k);
      exp_push(k, 4'(k + 1), 32'h1000_0000 + k);
    end
    #1 chk("all4_ready0", 64'(in_ready), 64'hF);
    cyc(); idle();
    chk("all4_pend4",  64'(pending_cnt), 64'd4);
    chk("all4_ready1", 64'(in_ready), 64'b0001);
    cyc();
    chk("all4_pend3",  64'(pending_cnt), 64'd3);
    chk("all4_ready2", 64'(in_ready), 64'b0011);
    cyc();
    chk("all4_pend2",  64'(pending_cnt), 64'd2);
    chk("all4_ready3", 64'(in_ready), 64'b0111);
    cyc();
    chk("all4_pend1",  64'(pending_cnt), 64'd1);
    chk("all4_ready4", 64'(in_ready), 64'b1111);
    cyc();
    chk("all4_last_valid", 64'(cdb_valid), 64'd1);
    chk("all4_pend0", 64'(pending_cnt), 64'd0);
    cyc();
    chk("all4_idle", 64'(cdb_valid), 64'd0);

    // continuous streaming on units 0 and 1
    for (int c = 0; c < 20; c++) begin
      er = (c == 0) ? 2'b11 : ((c % 2 == 1) ? 2'b01 : 2'b10);
      offer(0, 4'(na), 32'hA000_0000 + na);
      offer(1, 4'(nb), 32'hB000_0000 + nb);
      #1 chk("stream_ready", 64'(in_ready), 64'({2'b11, er}));
      if (er[0]) begin exp_push(0, 4'(na), 32'hA000_0000 + na); na++; end
      if (er[1]) begin exp_push(1, 4'(nb), 32'hB000_0000 + nb); nb++; end
      cyc();
    end
    idle();
    chk("stream_pend2", 64'(pending_cnt), 64'd2);
    cyc(); cyc();
    chk("stream_tail_valid", 64'(cdb_valid), 64'd1);
    chk("stream_tail_pend",  64'(pending_cnt), 64'd0);
    cyc();
    chk("stream_idle", 64'(cdb_valid), 64'd0);

    // flush with three results held and a live broadcast
    for (int k = 0; k < 4; k++) offer(k, 4'(8 + k), 32'hF000_0000 + k);
    exp_push(1, 4'd9, 32'hF000_0001);
    cyc(); idle();
    chk("fl_pend4", 64'(pending_cnt), 64'd4);
    cyc();
    chk("fl_pre_valid", 64'(cdb_valid), 64'd1);
    chk("fl_pre_pend",  64'(pending_cnt), 64'd3);
    flush = 1'b1;
    offer(1, 4'h7, 32'h7777_7777);
    #1 chk("fl_in_ready", 64'(in_ready), 64'd0);
    cyc();
    flush = 1'b0; idle();
    chk("fl_valid", 64'(cdb_valid), 64'd0);
    chk("fl_pend",  64'(pending_cnt), 64'd0);
    cyc();
    chk("fl_after_valid", 64'(cdb_valid), 64'd0);
    chk("fl_after_pend",  64'(pending_cnt), 64'd0);
    // rr_ptr held at 2 across flush: unit 2 before unit 0
    offer(0, 4'hD, 32'h0D0D_0D0D); offer(2, 4'hE, 32'h0E0E_0E0E);
    exp_push(2, 4'hE, 32'h0E0E_0E0E); exp_push(0, 4'hD, 32'h0D0D_0D0D);
    cyc(); idle(); cyc(); cyc();

    // reset mid-stream with two results held
    offer(1, 4'd5, 32'h5555_0001); offer(2, 4'd6, 32'h5555_0002); offer(3, 4'd7, 32'h5555_0003);
    exp_push(1, 4'd5, 32'h5555_0001);
    cyc(); idle();
    cyc();
    chk("mr_pre_valid", 64'(cdb_valid), 64'd1);
    chk("mr_pre_pend",  64'(pending_cnt), 64'd2);
    rst = 1'b1;
    #1 chk("mr_ready_rst", 64'(in_ready), 64'd0);
    cyc();
    chk("mr_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("mr_cdb_tag",   64'(cdb_tag),   64'd0);
    chk("mr_cdb_data",  64'(cdb_data),  64'd0);
    chk("mr_cdb_src",   64'(cdb_src),   64'd0);
    chk("mr_pend",      64'(pending_cnt), 64'd0);
    chk("mr_ready",     64'(in_ready),  64'd0);
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("mr_no_stale", 64'(cdb_valid), 64'd0);
    end
    // rr_ptr back at 0 after reset
    offer(1, 4'd2, 32'h2222_0001); offer(0, 4'd3, 32'h3333_0000);
    exp_push(0, 4'd3, 32'h3333_0000); exp_push(1, 4'd2, 32'h2222_0001);
    cyc(); idle(); cyc(); cyc(); cyc();
    chk("final_idle", 64'(cdb_valid), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
